mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and alongside the data cache.
- Arbitrates their single-word fill/write requests onto the one shared RAM port and returns wait/load to each cache.
- Grants are registered and held for a whole transaction. The dcache has fixed priority, with an anti-starvation counter that protects instruction fetch.
- Sits between the caches and the RAM model in the memory subsystem.

Parameters:
- STARVE_LIMIT, 4: max consecutive dcache grants issued while iREN is pending; the next arbitration goes to the icache.
- CNT_W, 3: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  icache read request, held until iwait=0.
- iaddr  in  32  icache word address.
- iwait  out  1  icache stall; 0 for exactly the completing cycle.
- iload  out  32  instruction word; valid when iwait=0.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  dcache stall; 0 for exactly the completing cycle.
- dload  out  32  data word; valid when dwait=0.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous, active-low, on nRST.
- States: IDLE, GNT_I, GNT_D. Only state and starve_cnt are registered.
- Reset:
  - State goes to IDLE and starve_cnt to 0.
  - Outputs during and after reset: iwait=1, dwait=1; ramREN, ramWEN, ramaddr, ramstore = 0; iload and dload = 0.
- IDLE: no RAM strobes; both waits are 1. Next state:
  - dreq=(dREN|dWEN) and iREN, with starve_cnt==STARVE_LIMIT: GNT_I.
  - Otherwise dreq: GNT_D.
  - Otherwise iREN: GNT_I.
  - Otherwise stay in IDLE.
- Request-to-strobe latency: one cycle. A request seen in IDLE at cycle N drives the RAM strobes from cycle N+1.
- GNT_D:
  - ramWEN=dWEN. ramREN=dREN & ~dWEN; if both are set, the write wins and the read is ignored.
  - ramaddr=daddr, ramstore=dstore.
  - dwait=~(ramstate==ACCESS); dload=ramload when ACCESS, else 0.
  - iwait=1.
- GNT_I:
  - ramREN=iREN, ramaddr=iaddr, ramWEN=0, ramstore=0.
  - iwait=~(ramstate==ACCESS); iload=ramload when ACCESS, else 0.
  - dwait=1.
- Completion: in the cycle ramstate==ACCESS, the granted wait drops to 0. Next state is IDLE, giving one mandatory bubble cycle between transactions.
- BUSY, FREE, ERROR while granted: hold the grant and strobes; wait stays 1. ERROR is never reported to the caches.
- Request withdrawn while granted (the granted requester's REN/WEN goes low):
  - Strobes follow the inputs combinationally, so they drop the same cycle.
  - Next state is IDLE; no completion is signalled.
- Starvation counter (starve_cnt), updated on the IDLE->GNT_D transition:
  - iREN=1: increment, saturating at STARVE_LIMIT.
  - iREN=0: clear to 0.
  - Any IDLE->GNT_I transition clears it to 0.
- Non-granted requester: its wait stays 1 and its load output is 0. Its inputs are ignored until arbitration.
- Simultaneous completion and new request: the new request is arbitrated in the following IDLE cycle, never in the completing cycle.
- Reset mid-transaction: RAM strobes drop asynchronously with nRST; the bench re-issues requests after reset.
- No arithmetic on addresses; all data and addresses pass through at 32 bits.

Decomposition:
- cpu_types_pkg (existing) supplies word_t and ramstate_t; use them for all 32-bit and ramstate ports.
- Add arb_state_t {IDLE, GNT_I, GNT_D} to cpu_types_pkg so the cache and system benches can probe the state.
- Single module, no sub-module: the starvation counter is a few lines inside the next-state always_comb/always_ff pair.

Test Plan:
- Lone ifetch: iREN=1, iaddr=0x100, RAM gives BUSY x2 then ACCESS with ramload=0xDEADBEEF -> ramREN high from cycle 1; iwait=0 and iload=0xDEADBEEF only in cycle 3; IDLE in cycle 4.
- Contention: iREN=1 and dREN=1 in the same IDLE cycle, daddr=0x200 -> GNT_D first, ramaddr=0x200; after the dcache completes plus the bubble, GNT_I with ramaddr=iaddr.
- Starvation: iREN held, dcache re-requests back-to-back, STARVE_LIMIT=4 -> exactly 4 dcache grants, then an icache grant; starve_cnt returns to 0.
- Write precedence: dREN=1, dWEN=1, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678; dwait=0 on ACCESS.
- Abort and reset: in GNT_I, iREN drops -> ramREN=0 the same cycle, IDLE next cycle, iwait never 0. Separately, assert nRST=0 mid-GNT_D -> strobes 0 immediately, iwait=dwait=1, IDLE after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-subsystem types: word and RAM status types used by the
// caches and RAM model, plus the arbiter state so benches can probe it.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    // Default arbitration tuning: dcache grants allowed while an ifetch waits.
    localparam int ARB_STARVE_LIMIT = 4;
    localparam int ARB_CNT_W        = 3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side and RAM-side signals around the memory arbiter.
// The slave view is what the arbiter sees; the master view is the
// surrounding caches and RAM model.
interface mem_arbiter_if;

    logic                      iREN;
    cpu_types_pkg::word_t      iaddr;
    logic                      iwait;
    cpu_types_pkg::word_t      iload;

    logic                      dREN;
    logic                      dWEN;
    cpu_types_pkg::word_t      daddr;
    cpu_types_pkg::word_t      dstore;
    logic                      dwait;
    cpu_types_pkg::word_t      dload;

    logic                      ramREN;
    logic                      ramWEN;
    cpu_types_pkg::word_t      ramaddr;
    cpu_types_pkg::word_t      ramstore;
    cpu_types_pkg::word_t      ramload;
    cpu_types_pkg::ramstate_t  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares the single RAM port between icache and dcache.
// The dcache has fixed priority, but after STARVE_LIMIT consecutive dcache
// grants taken while an ifetch is waiting, the icache is served next.
// Only the grant state and starvation counter are registered; RAM strobes
// and cache waits follow the inputs combinationally within a grant.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT,
    parameter int CNT_W        = ARB_CNT_W
) (
    input  logic           CLK,
    input  logic           nRST,
    mem_arbiter_if.slave   bus
);

    arb_state_t        state;
    arb_state_t        next_state;
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  next_cnt;
    logic              dreq;
    logic              access;

    assign dreq   = bus.dREN | bus.dWEN;
    assign access = (bus.ramstate == ACCESS);

    // Arbitration in IDLE and grant release on completion or withdrawal.
    always_comb begin
        next_state = state;
        next_cnt   = starve_cnt;
        case (state)
            IDLE: begin
                if (dreq && bus.iREN && (starve_cnt == CNT_W'(STARVE_LIMIT))) begin
                    next_state = GNT_I;
                    next_cnt   = '0;
                end else if (dreq) begin
                    next_state = GNT_D;
                    if (!bus.iREN) begin
                        next_cnt = '0;
                    end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                        next_cnt = starve_cnt + CNT_W'(1);
                    end
                end else if (bus.iREN) begin
                    next_state = GNT_I;
                    next_cnt   = '0;
                end
            end
            GNT_I: begin
                if (!bus.iREN || access) begin
                    next_state = IDLE;
                end
            end
            GNT_D: begin
                if (!dreq || access) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Grant state and starvation counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= next_state;
            starve_cnt <= next_cnt;
        end
    end

    // RAM strobes and cache handshakes for the current grant; a write beats
    // a read when the dcache raises both, and a withdrawn request never
    // reports completion.
    always_comb begin
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        case (state)
            GNT_I: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
                if (bus.iREN && access) begin
                    bus.iwait = 1'b0;
                    bus.iload = bus.ramload;
                end
            end
            GNT_D: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                if (dreq && access) begin
                    bus.dwait = 1'b0;
                    bus.dload = bus.ramload;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
